// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX stage.
// Accepts DIV/DIVU requests, runs WIDTH iterations, stalls the pipeline while
// busy, and presents {remainder, quotient} for HI/LO writeback.
// Build option: define DIV_ZERO_FAST_EN to short-circuit a zero divisor
// through a one-cycle path that returns an all-zero result.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stallreq
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t                state, state_nxt;

  // Working register layout: [2W:W+1] partial remainder, [W:1] shifting
  // dividend, quotient bits enter at [0] and walk up into [W-1:0].
  logic [2*WIDTH:0]      work, work_nxt;
  logic [WIDTH:0]        diff;
  logic [WIDTH-1:0]      divisor_abs;
  logic [WIDTH-1:0]      dividend_abs;
  logic [WIDTH-1:0]      divisor_in_abs;
  logic [CW-1:0]         cnt;
  logic                  sgn_q;
  logic                  dend_neg;
  logic                  dsor_neg;
  logic                  last_iter;
  logic [WIDTH-1:0]      quo_fix;
  logic [WIDTH-1:0]      rem_fix;
  logic                  accept;
  logic                  ready_nxt;
  logic [2*WIDTH-1:0]    result_nxt;
`ifdef DIV_ZERO_FAST_EN
  logic                  div_zero;
`endif

  assign stallreq = start & ~ready;
  assign accept   = start & ~annul;

`ifdef DIV_ZERO_FAST_EN
  assign div_zero = (opdata2 == '0);
`endif

  // Operand magnitudes: only DIV takes the absolute value of negative operands.
  always_comb begin
    dividend_abs   = (signed_div & opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
    divisor_in_abs = (signed_div & opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
  end

  // One restoring step: trial-subtract the divisor from the partial remainder.
  always_comb begin
    diff = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor_abs};
    if (diff[WIDTH]) begin
      work_nxt = work << 1;
    end else begin
      work_nxt = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
    end
  end

  // Sign fix-up applied to the value produced by the final iteration.
  always_comb begin
    last_iter = (cnt == CW'(WIDTH - 1));
    if (sgn_q & (dend_neg ^ dsor_neg)) begin
      quo_fix = ~work_nxt[WIDTH-1:0] + 1'b1;
    end else begin
      quo_fix = work_nxt[WIDTH-1:0];
    end
    if (sgn_q & dend_neg) begin
      rem_fix = ~work_nxt[2*WIDTH:WIDTH+1] + 1'b1;
    end else begin
      rem_fix = work_nxt[2*WIDTH:WIDTH+1];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FREE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and registered-output values; annul overrides everything.
  always_comb begin
    state_nxt  = state;
    ready_nxt  = 1'b0;
    result_nxt = '0;
    if (annul) begin
      state_nxt = S_FREE;
    end else begin
      case (state)
        S_FREE: begin
          if (start) begin
`ifdef DIV_ZERO_FAST_EN
            state_nxt = div_zero ? S_BYZERO : S_ON;
`else
            state_nxt = S_ON;
`endif
          end
        end
        S_BYZERO: begin
          if (!start) begin
            state_nxt = S_FREE;
          end else begin
            state_nxt = S_END;
            ready_nxt = 1'b1;
          end
        end
        S_ON: begin
          if (!start) begin
            state_nxt = S_FREE;
          end else if (last_iter) begin
            state_nxt  = S_END;
            ready_nxt  = 1'b1;
            result_nxt = {rem_fix, quo_fix};
          end
        end
        S_END: begin
          if (!start) begin
            state_nxt = S_FREE;
          end else begin
            ready_nxt  = 1'b1;
            result_nxt = result;
          end
        end
        default: begin
          state_nxt = S_FREE;
        end
      endcase
    end
  end

  // Operand capture on acceptance in Free; iterate while On.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work        <= '0;
      cnt         <= '0;
      divisor_abs <= '0;
      sgn_q       <= 1'b0;
      dend_neg    <= 1'b0;
      dsor_neg    <= 1'b0;
    end else if (state == S_FREE && accept) begin
      work        <= {{WIDTH{1'b0}}, dividend_abs, 1'b0};
      cnt         <= '0;
      divisor_abs <= divisor_in_abs;
      sgn_q       <= signed_div;
      dend_neg    <= opdata1[WIDTH-1];
      dsor_neg    <= opdata2[WIDTH-1];
    end else if (state == S_ON) begin
      work <= work_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  // Registered result/ready, cleared whenever not presenting a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready  <= 1'b0;
      result <= '0;
    end else begin
      ready  <= ready_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq with a magnitude-based
// arithmetic reference model and directed plus randomized requests.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  // Reference: divide magnitudes, then apply the sign rules, all mod 2^32.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint unsigned ma, mb, q, r;
    logic [31:0] qq, rr;
    ma = (sgn && a[31]) ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    mb = (sgn && b[31]) ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    q  = ma / mb;
    r  = ma % mb;
    qq = q[31:0];
    rr = r[31:0];
    if (sgn && (a[31] != b[31])) qq = 32'd0 - qq;
    if (sgn && a[31])            rr = 32'd0 - rr;
    return {rr, qq};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One request; pre=1 means start is already high in the current cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold, input bit pre);
    logic [63:0] expv;
    int lat, stalls, exp_lat;
    bit known;
    known   = 1'b1;
    exp_lat = 33;
    expv    = '0;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      exp_lat = 2;
`else
      known = 1'b0;
`endif
    end else begin
      expv = model(a, b, sgn);
    end
    if (!pre) begin
      @(posedge clk);
      #1;
      start = 1'b1;
    end
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    lat    = -1;
    stalls = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        break;
      end
      if (stallreq) stalls++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_cycles", 64'(stalls), 64'(exp_lat));
    check("stall_at_ready", {63'd0, stallreq}, 64'd0);
    if (known) check("result", result, expv);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ready", {63'd0, ready}, 64'd1);
      if (known) check("hold_result", result, expv);
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    opdata1 = $urandom;
    opdata2 = $urandom;
    @(negedge clk);
    check("end_until_edge", {63'd0, ready}, 64'd1);
    @(negedge clk);
    check("clear_ready", {63'd0, ready}, 64'd0);
    check("clear_result", result, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          seen;
    rst        = 1'b1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;

    // Reset state, stallreq follows start combinationally.
    #12;
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stallreq_hi", {63'd0, stallreq}, 64'd1);
    start = 1'b0;
    #1;
    check("rst_stallreq_lo", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
    check("model_100_7", model(32'd100, 32'd7, 1'b0), {32'h2, 32'hE});
    do_div(32'hFFFF_FFF9, 32'h2, 1'b1, 0, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    do_div(32'h1234_5678, 32'h0, 1'b0, 0, 1'b0);
    do_div(32'hF000_0001, 32'h0, 1'b1, 0, 1'b0);

    // Annul on the 10th On cycle while start stays high.
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall", {63'd0, stallreq}, 64'd1);
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("annul_ready", {63'd0, ready}, 64'd0);
    check("annul_result", result, 64'd0);
    do_div(32'd9, 32'd3, 1'b0, 0, 1'b1);

    // Result held while EX keeps start high.
    do_div(32'd100, 32'd7, 1'b0, 5, 1'b0);
    do_div(32'hFFFF_FFF9, 32'h2, 1'b1, 5, 1'b0);

    // Asynchronous reset in the middle of On.
    @(posedge clk);
    #1;
    start   = 1'b1;
    opdata1 = 32'd55555;
    opdata2 = 32'd11;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_on_ready", {63'd0, ready}, 64'd0);
    check("rst_on_result", result, 64'd0);
    start = 1'b0;
    #1;
    rst = 1'b0;
    do_div(32'd55555, 32'd11, 1'b0, 0, 1'b0);

    // Asynchronous reset while a result is being held.
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    seen       = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_end_seen", {63'd0, seen}, 64'd1);
    check("rst_end_pre_result", result, {32'h2, 32'hE});
    #2;
    rst = 1'b1;
    #1;
    check("rst_end_ready", {63'd0, ready}, 64'd0);
    check("rst_end_result", result, 64'd0);
    start = 1'b0;
    #1;
    rst = 1'b0;

    // Randomized requests.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(1, 15);
        1:       rb = $urandom;
        2:       rb = 32'd0 - $urandom_range(1, 15);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, $urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle divide sequencer for the EX stage. It accepts a signed or unsigned 32-bit divide request from EX and runs a radix-2 restoring division over 32 iterations. While busy it raises a stall request to the pipeline controller, then presents a 64-bit {remainder, quotient} result for HI/LO writeback. It sits beside the ALU in EX, and its `stallreq` feeds the same stall-bus generator as ID's load-use `stallreq`.

## Interface
- `WIDTH`, 32: operand width; iteration count equals `WIDTH`.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: divide request from EX. Held high until `ready` is seen.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU. Sampled with `start` in Free.
- `opdata1` in WIDTH: dividend. Sampled with `start` in Free.
- `opdata2` in WIDTH: divisor. Sampled with `start` in Free.
- `annul` in 1: flush. Aborts any in-flight divide.
- `result` out 2*WIDTH: {remainder[63:32] (HI), quotient[31:0] (LO)}. Valid only while `ready`=1, otherwise 0.
- `ready` out 1: result valid, registered.
- `stallreq` out 1: combinational, equals `start & ~ready`.

## Operation
- States: Free, ByZero, On, End. Reset value: Free.
- Free:
  - `start`=1 & `annul`=0 & divisor≠0 → On.
  - Divisor=0 → ByZero (when `DIV_ZERO_FAST_EN` is defined) or On (when it is not).
  - On entry to On: latch `|opdata1|`, `|opdata2|` (absolute values only when `signed_div`), `signed_div`, and both operand sign bits. Clear the 6-bit counter. Load the 65-bit working register with {32'b0, |dividend|, 1'b0}.
- On, each cycle:
  - Compute `diff` = working[63:32] − |divisor| (33-bit).
  - If `diff` is negative: shift working left by 1, inserting 0.
  - Otherwise: working = {diff[31:0], working[31:0], 1'b1}.
  - Increment the counter.
  - When the counter reaches WIDTH: → End. Quotient = working[31:0]; remainder = working[64:33].
- Sign fix-up, applied on the last On cycle when `signed_div`:
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative.
  - Arithmetic wraps modulo 2^32. For example, 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- ByZero: one cycle; result forced to 0; → End.
- End:
  - `ready`=1 and `result` is driven.
  - `start`=0 → Free; the result is cleared next cycle.
  - `start` still high (EX stalled) → remain in End, holding the result.
- `annul`=1 in any state → Free next cycle, with `ready`=0 and the result cleared. `annul` has priority over `start`.
- `start` dropping while in On or ByZero is treated as an abort → Free.
- Asynchronous reset mid-operation: state Free, counter 0, `ready`=0, `result`=0 immediately.

## Timing
- Outputs at reset: `ready`=0, `result`=0, `stallreq`=`start`.
- `start` is first seen in Free at edge N.
  - The On cycles are N+1 through N+32.
  - `ready` is high in cycle N+33, so latency is 33 cycles.
  - `stallreq` is high from cycle N-1 (combinational on `start`) through N+32, and low in N+33.
- Back-to-back divides:
  - EX drops `start` for at least 1 cycle after `ready`.
  - A new `start` arriving in the same cycle as the End→Free transition is sampled in the following cycle. A minimum of 1 idle Free cycle is required.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - A zero divisor takes the ByZero path; `ready` is high at N+2.
  - Result = 64'b0.
  - `stallreq` is high for 2 cycles.
- `DIV_ZERO_FAST_EN` undefined:
  - A zero divisor runs the full 32 On iterations; `ready` is high at N+33.
  - Result is the raw restoring output after sign fix-up. The architectural value is UNPREDICTABLE; only latency is checked.

## Test plan
- Unsigned 100 / 7 (`signed_div`=0):
  - `ready` is high exactly 33 cycles after `start` is sampled.
  - `result` = {0x00000002, 0x0000000E}.
  - `stallreq` is high for 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): `result` = {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF: `result` = {0x00000000, 0x80000000}, with no hang.
- Divisor 0 with `DIV_ZERO_FAST_EN`: `ready` at N+2, `result`=0. Without the macro: `ready` at N+33.
- `annul` asserted on the 10th On cycle:
  - Next cycle is Free, with `ready`=0 and `result`=0.
  - A following 9 / 3 request returns {0, 3} with full latency.
- `start` held 5 cycles past `ready`: `result` is held stable for those 5 cycles. After `start` drops, `result`=0. Async `rst` pulsed mid-On forces `ready`/`result` to 0 without a clock edge.
